// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter sharing one W-bit one-shot timer among NREQ requesters.
// The timer counts rising edges of tick_in, sampled on i_qzt_clk, and pulses done to the owner.
module tick_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              i_qzt_clk,
  input  logic              i_rst,
  input  logic              i_tick_in,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_limit_bus,
  output logic [NREQ-1:0]   o_grant,
  output logic [NREQ-1:0]   o_done,
  output logic              o_busy,
  output logic [W-1:0]      o_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // state  | meaning
  // IDLE   | no owner; arbitrate among requests
  // ARM    | owner latched, count cleared; ticks in this cycle are ignored
  // COUNT  | counting tick rising edges toward lim
  // DONE   | done pulse to owner; release next cycle
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [W-1:0]    r_lim;
  logic [W-1:0]    r_count;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic            r_tick_old;

  logic            w_tick_rise;
  logic            w_abort;
  logic            w_win_vld;
  logic [PW-1:0]   w_win_idx;
  logic [W-1:0]    w_count_inc;

  assign w_tick_rise = i_tick_in & ~r_tick_old;
  assign w_count_inc = r_count + W'(1);
  // Abort outranks expiry: a dropped request never sees a done pulse.
  assign w_abort     = ((r_state == S_ARM) || (r_state == S_COUNT)) && !i_req[r_owner];

  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      v_idx = int'(r_rr_ptr) + i;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_win_vld && i_req[v_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = PW'(v_idx);
      end
    end
  end

  always_ff @(posedge i_qzt_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= PW'(NREQ - 1);
      r_owner    <= '0;
      r_lim      <= '0;
      r_count    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_tick_old <= 1'b0;
    end else begin
      r_tick_old <= i_tick_in;
      r_done     <= '0;
      if (w_abort) begin
        r_grant  <= '0;
        r_busy   <= 1'b0;
        r_rr_ptr <= r_owner;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_win_vld) begin
              r_owner <= w_win_idx;
              r_grant <= NREQ'(1) << w_win_idx;
              r_lim   <= i_limit_bus[w_win_idx*W +: W];
              r_count <= '0;
              r_busy  <= 1'b1;
              r_state <= S_ARM;
            end
          end
          S_ARM: begin
            if (r_lim == '0) begin
              r_done  <= r_grant;
              r_state <= S_DONE;
            end else begin
              r_state <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (w_tick_rise) begin
              r_count <= w_count_inc;
              if (w_count_inc == r_lim) begin
                r_done  <= r_grant;
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= r_owner;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_busy  = r_busy;
  assign o_count = r_count;
endmodule
